// File: rtl/vectored_interrupt_controller_if.sv
// Handshake between the interrupt controller and the hazard control unit.
// The controller drives the request side; the hazard unit drives state, ack and return.
interface vectored_interrupt_controller_if #(
  parameter int ADDR_W  = 14,
  parameter int ID_W    = 3,
  parameter int STATE_W = 4
);
  logic [STATE_W-1:0] hazard_unit_state;
  logic               int_ack;
  logic               int_ret;
  logic               interrupt;
  logic [ADDR_W-1:0]  int_vec_addr;
  logic [ID_W-1:0]    int_id;
  logic               in_service;

  modport master (
    input  hazard_unit_state, int_ack, int_ret,
    output interrupt, int_vec_addr, int_id, in_service
  );

  modport slave (
    output hazard_unit_state, int_ack, int_ret,
    input  interrupt, int_vec_addr, int_id, in_service
  );
endinterface

// File: rtl/vectored_interrupt_controller.sv
// Multi-channel vectored interrupt controller: per-channel edge/level latching, masking,
// fixed-priority arbitration and a request/ack/return handshake toward the hazard unit.
module vectored_interrupt_controller #(
  parameter int                 NUM_IRQ         = 8,
  parameter int                 ADDR_W          = 14,
  parameter logic [ADDR_W-1:0]  VEC_BASE        = 14'h0010,
  parameter int                 VEC_STRIDE_LOG2 = 2,
  parameter int                 STATE_W         = 4,
  parameter logic [STATE_W-1:0] ACCEPT_STATE    = 4'h0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic [NUM_IRQ-1:0]  irq_mask_en,
  input  logic [NUM_IRQ-1:0]  irq_edge_mode,
  input  logic                global_en,
  input  logic [NUM_IRQ-1:0]  sw_clear,
  output logic [NUM_IRQ-1:0]  pending,
  vectored_interrupt_controller_if.master hz
);
  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state;
  state_t             state_next;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] pending_next;
  logic [NUM_IRQ-1:0] eligible;
  logic [ID_W-1:0]    sel_id;
  logic [ADDR_W-1:0]  sel_vec;
  logic               ack_fire;

  assign ack_fire = (state == REQ) && hz.int_ack;
  assign eligible = global_en ? (pending & irq_mask_en) : '0;

  // Edge channels: a new rise beats any clear arriving in the same cycle.
  always_comb begin
    pending_next = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (irq_edge_mode[i])
        pending_next[i] = (irq_in[i] & ~irq_prev[i]) |
                          (pending[i] & ~(sw_clear[i] | (ack_fire && (hz.int_id == ID_W'(i)))));
      else
        pending_next[i] = irq_in[i];
    end
  end

  always_comb begin
    sel_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel_id = ID_W'(i);
    end
    sel_vec = VEC_BASE + (ADDR_W'(sel_id) << VEC_STRIDE_LOG2);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      irq_prev <= '0;
      pending  <= '0;
    end else begin
      irq_prev <= irq_in;
      pending  <= pending_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A raised request is committed: only int_ack can retire it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if ((|eligible) && (hz.hazard_unit_state == ACCEPT_STATE)) state_next = REQ;
      REQ:     if (hz.int_ack) state_next = SERVICE;
      SERVICE: if (hz.int_ret) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hz.int_id       <= '0;
      hz.int_vec_addr <= VEC_BASE;
    end else if ((state == IDLE) && (state_next == REQ)) begin
      hz.int_id       <= sel_id;
      hz.int_vec_addr <= sel_vec;
    end
  end

  always_comb begin
    hz.interrupt  = (state == REQ);
    hz.in_service = (state == SERVICE);
  end
endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// Directed testbench for vectored_interrupt_controller with hand-computed expectations.
// A second instance with VEC_BASE = 14'h3FFC exercises vector address wrap-around.
module tb_vectored_interrupt_controller;
  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  irq_in, irq_mask_en, irq_edge_mode, sw_clear;
  logic        global_en;
  logic [3:0]  hazard_state;
  logic        int_ack, int_ret;
  logic [7:0]  pending, pending_w;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  vectored_interrupt_controller_if #(.ADDR_W(14), .ID_W(3), .STATE_W(4)) hz0 ();
  vectored_interrupt_controller_if #(.ADDR_W(14), .ID_W(3), .STATE_W(4)) hzw ();

  assign hz0.hazard_unit_state = hazard_state;
  assign hz0.int_ack           = int_ack;
  assign hz0.int_ret           = int_ret;
  assign hzw.hazard_unit_state = hazard_state;
  assign hzw.int_ack           = int_ack;
  assign hzw.int_ret           = int_ret;

  vectored_interrupt_controller dut (
    .clock(clock), .reset(reset), .irq_in(irq_in), .irq_mask_en(irq_mask_en),
    .irq_edge_mode(irq_edge_mode), .global_en(global_en), .sw_clear(sw_clear),
    .pending(pending), .hz(hz0)
  );

  vectored_interrupt_controller #(.VEC_BASE(14'h3FFC)) dut_wrap (
    .clock(clock), .reset(reset), .irq_in(irq_in), .irq_mask_en(irq_mask_en),
    .irq_edge_mode(irq_edge_mode), .global_en(global_en), .sw_clear(sw_clear),
    .pending(pending_w), .hz(hzw)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    irq_in = '0; irq_mask_en = 8'hFF; irq_edge_mode = 8'hFF; sw_clear = '0;
    global_en = 1'b1; hazard_state = 4'h0; int_ack = 1'b0; int_ret = 1'b0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic ack_and_ret();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    int_ret = 1'b1; step(); int_ret = 1'b0;
  endtask

  task automatic test_reset();
    irq_in = 8'hFF; irq_edge_mode = '0; irq_mask_en = 8'hFF; global_en = 1'b1;
    sw_clear = '0; hazard_state = 4'h0; int_ack = 1'b0; int_ret = 1'b0;
    reset = 1'b1;
    step(); step();
    checks++; if (hz0.interrupt !== 1'b0) begin errors++; $display("[TB] FAIL reset_interrupt got %b want 0", hz0.interrupt); end
    checks++; if (hz0.in_service !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_service got %b want 0", hz0.in_service); end
    checks++; if (hz0.int_id !== 3'd0) begin errors++; $display("[TB] FAIL reset_int_id got %0d want 0", hz0.int_id); end
    checks++; if (hz0.int_vec_addr !== 14'h0010) begin errors++; $display("[TB] FAIL reset_vec got %h want 0010", hz0.int_vec_addr); end
    checks++; if (pending !== 8'h00) begin errors++; $display("[TB] FAIL reset_pending got %h want 00", pending); end
    irq_in = '0;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_edge();
    do_reset();
    irq_in = 8'h08;
    step();
    checks++; if (pending !== 8'h08) begin errors++; $display("[TB] FAIL edge_pending_set got %h want 08", pending); end
    checks++; if (hz0.interrupt !== 1'b0) begin errors++; $display("[TB] FAIL edge_latency got %b want 0", hz0.interrupt); end
    step();
    checks++; if (hz0.interrupt !== 1'b1) begin errors++; $display("[TB] FAIL edge_interrupt got %b want 1", hz0.interrupt); end
    checks++; if (hz0.int_id !== 3'd3) begin errors++; $display("[TB] FAIL edge_id got %0d want 3", hz0.int_id); end
    checks++; if (hz0.int_vec_addr !== 14'h001C) begin errors++; $display("[TB] FAIL edge_vec got %h want 001C", hz0.int_vec_addr); end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    checks++; if (hz0.interrupt !== 1'b0) begin errors++; $display("[TB] FAIL ack_interrupt got %b want 0", hz0.interrupt); end
    checks++; if (hz0.in_service !== 1'b1) begin errors++; $display("[TB] FAIL ack_in_service got %b want 1", hz0.in_service); end
    checks++; if (pending[3] !== 1'b0) begin errors++; $display("[TB] FAIL ack_clears_pending got %b want 0", pending[3]); end
    int_ret = 1'b1; step(); int_ret = 1'b0;
    checks++; if (hz0.in_service !== 1'b0) begin errors++; $display("[TB] FAIL ret_in_service got %b want 0", hz0.in_service); end
    step();
    checks++; if (hz0.interrupt !== 1'b0) begin errors++; $display("[TB] FAIL ret_no_rerequest got %b want 0", hz0.interrupt); end
    irq_in = '0;
  endtask

  task automatic test_priority();
    do_reset();
    irq_in = 8'h24;
    step(); step();
    checks++; if (hz0.int_id !== 3'd2) begin errors++; $display("[TB] FAIL prio_first_id got %0d want 2", hz0.int_id); end
    checks++; if (hz0.int_vec_addr !== 14'h0018) begin errors++; $display("[TB] FAIL prio_first_vec got %h want 0018", hz0.int_vec_addr); end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    checks++; if (pending !== 8'h20) begin errors++; $display("[TB] FAIL prio_pending got %h want 20", pending); end
    int_ret = 1'b1; step(); int_ret = 1'b0;
    checks++; if (hz0.interrupt !== 1'b0) begin errors++; $display("[TB] FAIL prio_ret_idle got %b want 0", hz0.interrupt); end
    step();
    checks++; if (hz0.interrupt !== 1'b1) begin errors++; $display("[TB] FAIL prio_second_req got %b want 1", hz0.interrupt); end
    checks++; if (hz0.int_id !== 3'd5) begin errors++; $display("[TB] FAIL prio_second_id got %0d want 5", hz0.int_id); end
    checks++; if (hz0.int_vec_addr !== 14'h0024) begin errors++; $display("[TB] FAIL prio_second_vec got %h want 0024", hz0.int_vec_addr); end
    ack_and_ret();
    irq_in = '0;
  endtask

  task automatic test_masking();
    do_reset();
    irq_mask_en = 8'hFD;
    irq_in = 8'h02;
    step(); step(); step();
    checks++; if (pending !== 8'h02) begin errors++; $display("[TB] FAIL mask_pending got %h want 02", pending); end
    checks++; if (hz0.interrupt !== 1'b0) begin errors++; $display("[TB] FAIL mask_holds got %b want 0", hz0.interrupt); end
    irq_mask_en = 8'hFF;
    step();
    checks++; if (hz0.interrupt !== 1'b1) begin errors++; $display("[TB] FAIL unmask_req got %b want 1", hz0.interrupt); end
    checks++; if (hz0.int_id !== 3'd1) begin errors++; $display("[TB] FAIL unmask_id got %0d want 1", hz0.int_id); end
    ack_and_ret();
    hazard_state = 4'h3;
    irq_in = 8'h00; step();
    irq_in = 8'h02; step(); step(); step();
    checks++; if (hz0.interrupt !== 1'b0) begin errors++; $display("[TB] FAIL hazard_holds got %b want 0", hz0.interrupt); end
    hazard_state = 4'h0;
    step();
    checks++; if (hz0.interrupt !== 1'b1) begin errors++; $display("[TB] FAIL hazard_release got %b want 1", hz0.interrupt); end
    ack_and_ret();
    irq_in = '0;
  endtask

  task automatic test_level();
    do_reset();
    irq_edge_mode = 8'hFE;
    irq_in = 8'h01;
    step(); step();
    checks++; if (hz0.interrupt !== 1'b1 || hz0.int_id !== 3'd0) begin errors++; $display("[TB] FAIL level_req got int=%b id=%0d want int=1 id=0", hz0.interrupt, hz0.int_id); end
    sw_clear = 8'h01; step(); sw_clear = '0;
    checks++; if (pending[0] !== 1'b1) begin errors++; $display("[TB] FAIL level_sw_clear got %b want 1", pending[0]); end
    irq_in = 8'h00; step(); step();
    checks++; if (pending[0] !== 1'b0) begin errors++; $display("[TB] FAIL level_follows got %b want 0", pending[0]); end
    checks++; if (hz0.interrupt !== 1'b1) begin errors++; $display("[TB] FAIL committed_req got %b want 1", hz0.interrupt); end
    ack_and_ret();
    irq_in = 8'h10; sw_clear = 8'h10; step(); sw_clear = '0;
    checks++; if (pending[4] !== 1'b1) begin errors++; $display("[TB] FAIL set_beats_clear got %b want 1", pending[4]); end
    step();
    sw_clear = 8'h10; step(); sw_clear = '0;
    checks++; if (pending[4] !== 1'b0) begin errors++; $display("[TB] FAIL sw_clear_edge got %b want 0", pending[4]); end
    checks++; if (hz0.interrupt !== 1'b1 || hz0.int_id !== 3'd4) begin errors++; $display("[TB] FAIL clear_committed got int=%b id=%0d want int=1 id=4", hz0.interrupt, hz0.int_id); end
    ack_and_ret();
    irq_in = '0;
  endtask

  task automatic test_reset_mid_service();
    do_reset();
    irq_in = 8'h48;
    step(); step();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    checks++; if (hz0.in_service !== 1'b1 || pending !== 8'h40) begin errors++; $display("[TB] FAIL pre_reset got svc=%b pend=%h want svc=1 pend=40", hz0.in_service, pending); end
    reset = 1'b1; step();
    checks++; if (hz0.in_service !== 1'b0 || hz0.interrupt !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_state got svc=%b int=%b want 0 0", hz0.in_service, hz0.interrupt); end
    checks++; if (pending !== 8'h00) begin errors++; $display("[TB] FAIL mid_reset_pending got %h want 00", pending); end
    irq_in = '0; step();
    reset = 1'b0; step();
  endtask

  task automatic test_wrap();
    do_reset();
    checks++; if (hzw.int_vec_addr !== 14'h3FFC) begin errors++; $display("[TB] FAIL wrap_reset_vec got %h want 3FFC", hzw.int_vec_addr); end
    irq_in = 8'h04;
    step(); step();
    checks++; if (hzw.interrupt !== 1'b1 || hzw.int_id !== 3'd2) begin errors++; $display("[TB] FAIL wrap_req got int=%b id=%0d want int=1 id=2", hzw.interrupt, hzw.int_id); end
    checks++; if (hzw.int_vec_addr !== 14'h0004) begin errors++; $display("[TB] FAIL wrap_vec got %h want 0004", hzw.int_vec_addr); end
    ack_and_ret();
    irq_in = '0;
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_single_edge();
    test_priority();
    test_masking();
    test_level();
    test_reset_mid_service();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
